// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with level flags and sticky errors
//
// Purpose:
//   Single-clock FIFO, DEPTH = 2**ADDR_W words of DATA_W bits. It provides:
//   - a fill-level count
//   - almost-full and almost-empty flags with programmable thresholds
//   - sticky overflow and underflow error flags
//   - a synchronous flush
//
// Optional feature:
//   Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
//   - When it is defined, r_data shows mem[rd_ptr] combinationally and r_en pops the word.
//   - When it is undefined, the read port is registered and has 1-cycle latency,
//     so the memory can map to block RAM.
//
// Ports:
//   clk          in   single clock
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear of pointers, count and flags
//   w_en, w_data in   write request / data
//   w_full       out  FIFO full, writes ignored
//   almost_full  out  count >= AFULL_TH
//   r_en         in   read request (pop in FWFT mode)
//   r_data       out  read data
//   r_empty      out  FIFO empty, reads ignored
//   almost_empty out  count <= AEMPTY_TH
//   count        out  stored words, 0..DEPTH
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//   clr_err      in   synchronous clear of overflow/underflow
module sync_fifo_param #(
   parameter int DATA_W    = 560,
   parameter int ADDR_W    = 5,
   parameter int AFULL_TH  = 28,
   parameter int AEMPTY_TH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              w_en,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_full,
   output logic              almost_full,
   input  logic              r_en,
   output logic [DATA_W-1:0] r_data,
   output logic              r_empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int            DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_d;
   logic              wr_ok;
   logic              rd_ok;

   // Acceptance uses this cycle's registered flags, so a read never frees
   // space for a same-cycle write and a write never feeds a same-cycle read.
   assign wr_ok = w_en & ~w_full & ~flush;
   assign rd_ok = r_en & ~r_empty & ~flush;

   // Flags are registered from the next count so they are exact one cycle
   // after the event; flush forces the next count to zero.
   always_comb begin
      count_d = count;
      if (flush)
         count_d = '0;
      else if (wr_ok && !rd_ok)
         count_d = count + 1'b1;
      else if (rd_ok && !wr_ok)
         count_d = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         w_full       <= 1'b0;
         r_empty      <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         end
         count        <= count_d;
         w_full       <= (count_d == DEPTH_C);
         r_empty      <= (count_d == '0);
         almost_full  <= (count_d >= AFULL_C);
         almost_empty <= (count_d <= AEMPTY_C);
      end
   end

   // Error flags are untouched by flush; a new error beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (!flush) begin
         overflow  <= (w_en & w_full)  | (overflow  & ~clr_err);
         underflow <= (r_en & r_empty) | (underflow & ~clr_err);
      end
   end

   // Storage is never reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= w_data;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign r_data = mem[rd_ptr];
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_data <= '0;
      else if (rd_ok)
         r_data <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

   localparam int DATA_W    = 560;
   localparam int ADDR_W    = 5;
   localparam int DEPTH     = 32;
   localparam int AFULL_TH  = 28;
   localparam int AEMPTY_TH = 4;

   typedef logic [DATA_W-1:0] word_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush, w_en, r_en, clr_err;
   word_t           w_data;
   word_t           r_data;
   logic            w_full, almost_full, r_empty, almost_empty;
   logic [ADDR_W:0] count;
   logic            overflow, underflow;

   sync_fifo_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .w_en(w_en), .w_data(w_data), .w_full(w_full), .almost_full(almost_full),
      .r_en(r_en), .r_data(r_data), .r_empty(r_empty), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of stored words plus the sticky error bits.
   word_t q[$];
   logic  m_ovf, m_unf;
   word_t m_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input word_t act, input word_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic word_t rand_word();
      word_t w = '0;
      for (int i = 0; i < DATA_W; i += 32) w = {w[DATA_W-33:0], 32'($urandom())};
      return w;
   endfunction

   task automatic check_state(input string tag);
      int n = q.size();
      check({tag, "_count"},  word_t'(count),        word_t'(n));
      check({tag, "_full"},   word_t'(w_full),       word_t'(n == DEPTH));
      check({tag, "_empty"},  word_t'(r_empty),      word_t'(n == 0));
      check({tag, "_afull"},  word_t'(almost_full),  word_t'(n >= AFULL_TH));
      check({tag, "_aempty"}, word_t'(almost_empty), word_t'(n <= AEMPTY_TH));
      check({tag, "_ovf"},    word_t'(overflow),     word_t'(m_ovf));
      check({tag, "_unf"},    word_t'(underflow),    word_t'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      if (n != 0) check({tag, "_rdata"}, r_data, q[0]);
`else
      check({tag, "_rdata"}, r_data, m_rdata);
`endif
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic tick(input string tag, input logic we, input logic re,
                       input logic fl, input logic ce, input word_t wd);
      logic full_now, empty_now;
      w_en = we; r_en = re; flush = fl; clr_err = ce; w_data = wd;
      full_now  = (q.size() == DEPTH);
      empty_now = (q.size() == 0);
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (re && !empty_now) m_rdata = q.pop_front();
         if (we && !full_now)  q.push_back(wd);
         m_ovf = (we && full_now)  || (m_ovf && !ce);
         m_unf = (re && empty_now) || (m_unf && !ce);
      end
      #1;
      check_state(tag);
      w_en = 0; r_en = 0; flush = 0; clr_err = 0;
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdata = '0;
   endtask

   initial begin
      rst_n = 0; flush = 0; w_en = 0; r_en = 0; clr_err = 0; w_data = '0;
      model_reset();
      #12;
      check_state("reset");
      rst_n = 1;

      // Fill 0..31, then one write too many.
      for (int i = 0; i < DEPTH; i++) tick("fill", 1, 0, 0, 0, word_t'(i));
      check("tp1_count", word_t'(count), word_t'(32));
      check("tp1_full",  word_t'(w_full), word_t'(1));
      tick("ovf", 1, 0, 0, 0, word_t'(99));
      check("tp1_ovf", word_t'(overflow), word_t'(1));

      // Drain 0..31, then one read too many.
      for (int i = 0; i < DEPTH; i++) tick("drain", 0, 1, 0, 0, '0);
      check("tp2_last", r_data, word_t'(31));
      tick("unf", 0, 1, 0, 0, '0);
      check("tp2_unf", word_t'(underflow), word_t'(1));

      // Steady level of 10 with simultaneous traffic; pointers wrap.
      tick("clr", 0, 0, 0, 1, '0);
      for (int i = 0; i < 10; i++) tick("lvl", 1, 0, 0, 0, rand_word());
      for (int i = 0; i < 20; i++) tick("both", 1, 1, 0, 0, rand_word());
      check("tp3_count", word_t'(count), word_t'(10));

      // Full with both requests, then empty with both requests.
      for (int i = 0; i < 22; i++) tick("fill2", 1, 0, 0, 0, rand_word());
      tick("full_both", 1, 1, 0, 0, rand_word());
      check("tp4_count_full", word_t'(count), word_t'(31));
      for (int i = 0; i < 31; i++) tick("drain2", 0, 1, 0, 0, '0);
      tick("empty_both", 1, 1, 0, 0, rand_word());
      check("tp4_count_empty", word_t'(count), word_t'(1));

      // Flush at 17 with both requests, then reuse and clear errors.
      for (int i = 0; i < 16; i++) tick("to17", 1, 0, 0, 0, rand_word());
      tick("flush", 1, 1, 1, 0, rand_word());
      check("tp5_count", word_t'(count), word_t'(0));
      tick("post_w", 1, 0, 0, 0, rand_word());
      tick("post_r", 0, 1, 0, 0, '0);
      tick("clr2", 0, 0, 0, 1, '0);
      check("tp5_ovf", word_t'(overflow), word_t'(0));

      // Asynchronous reset mid-burst at count 12.
      for (int i = 0; i < 12; i++) tick("to12", 1, 0, 0, 0, rand_word());
      tick("mk_err", 0, 0, 0, 0, '0);
      #2 rst_n = 0;
      #1;
      model_reset();
      check_state("async_rst");
      #1 rst_n = 1;

      // Randomized traffic with occasional flush and error clear.
      for (int i = 0; i < 600; i++) begin
         int mode = (i / 100) % 3;
         logic we = ($urandom_range(0, 9) < (mode == 0 ? 8 : (mode == 1 ? 3 : 5)));
         logic re = ($urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 8 : 5)));
         logic fl = ($urandom_range(0, 59) == 0);
         logic ce = ($urandom_range(0, 19) == 0);
         tick("rand", we, re, fl, ce, rand_word());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
